// File: rtl/gpio_port_ctrl_if.sv
// Register bus between the bus bridge (master) and one GPIO port controller (slave).
interface gpio_port_ctrl_if;
   logic        reg_wr;
   logic        reg_rd;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   modport master (output reg_wr, reg_rd, reg_addr, reg_wdata, input reg_rdata);
   modport slave  (input reg_wr, reg_rd, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: pad configuration/output registers, input synchroniser,
// edge detection into write-1-clear pending flags and a level interrupt.
module gpio_port_ctrl #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpio_port_ctrl_if.slave      bus,
   output logic [WIDTH-1:0]     pad_out,
   output logic [WIDTH-1:0]     pad_dir,
   output logic [WIDTH-1:0]     pad_type,
   output logic [2*WIDTH-1:0]   pad_speed,
   output logic [2*WIDTH-1:0]   pad_pupd,
   input  logic [WIDTH-1:0]     pad_in,
   output logic                 irq
);

   typedef enum logic [3:0] {
      A_DIR = 4'h0, A_TYPE = 4'h1, A_OUT  = 4'h2, A_BSR   = 4'h3,
      A_IN  = 4'h4, A_IE   = 4'h5, A_RISE = 4'h6, A_FALL  = 4'h7,
      A_PEND = 4'h8, A_SPEED = 4'h9, A_PUPD = 4'hA
   } addr_e;

   logic [WIDTH-1:0]   dir_q, dir_d, type_q, type_d, out_q, out_d;
   logic [WIDTH-1:0]   ie_q, ie_d, rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
   logic [2*WIDTH-1:0] speed_q, speed_d, pupd_q, pupd_d;
   logic [31:0]        rdata_q, rdata_d, rd_val;
   logic               irq_q, irq_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]   prev_q, sync_in, rise_ev, fall_ev, pend_set, pend_clr;
   logic [1:0]         warm_q;
   logic               dly_q, warm_inc, edge_en;

   assign sync_in = sync_q[SYNC_STAGES-1];
   assign rise_ev = sync_in & ~prev_q;
   assign fall_ev = ~sync_in & prev_q;

   // A 3-deep synchroniser needs one extra masked cycle, so the counter
   // idles for the first cycle after reset in that configuration.
   assign warm_inc = (SYNC_STAGES < 3) || dly_q;
   assign edge_en  = (warm_q == 2'd3);
   assign pend_set = edge_en ? ((rise_ev & rise_q) | (fall_ev & fall_q)) : '0;

   always_comb begin
      dir_d    = dir_q;
      type_d   = type_q;
      out_d    = out_q;
      ie_d     = ie_q;
      rise_d   = rise_q;
      fall_d   = fall_q;
      speed_d  = speed_q;
      pupd_d   = pupd_q;
      pend_clr = '0;
      if (bus.reg_wr) begin
         case (bus.reg_addr)
            A_DIR:   dir_d   = bus.reg_wdata[WIDTH-1:0];
            A_TYPE:  type_d  = bus.reg_wdata[WIDTH-1:0];
            A_OUT:   out_d   = bus.reg_wdata[WIDTH-1:0];
            // Set is applied after clear so it wins on a shared bit.
            A_BSR:   out_d   = (out_q & ~bus.reg_wdata[16 +: WIDTH]) | bus.reg_wdata[WIDTH-1:0];
            A_IE:    ie_d    = bus.reg_wdata[WIDTH-1:0];
            A_RISE:  rise_d  = bus.reg_wdata[WIDTH-1:0];
            A_FALL:  fall_d  = bus.reg_wdata[WIDTH-1:0];
            A_PEND:  pend_clr = bus.reg_wdata[WIDTH-1:0];
            A_SPEED: speed_d = bus.reg_wdata[2*WIDTH-1:0];
            A_PUPD:  pupd_d  = bus.reg_wdata[2*WIDTH-1:0];
            default: ;
         endcase
      end
      pend_d = (pend_q & ~pend_clr) | pend_set;
      irq_d  = |(pend_q & ie_q);
   end

   always_comb begin
      rd_val = '0;
      case (bus.reg_addr)
         A_DIR:   rd_val = 32'(dir_q);
         A_TYPE:  rd_val = 32'(type_q);
         A_OUT:   rd_val = 32'(out_q);
         A_IN:    rd_val = 32'(sync_in);
         A_IE:    rd_val = 32'(ie_q);
         A_RISE:  rd_val = 32'(rise_q);
         A_FALL:  rd_val = 32'(fall_q);
         A_PEND:  rd_val = 32'(pend_q);
         A_SPEED: rd_val = 32'(speed_q);
         A_PUPD:  rd_val = 32'(pupd_q);
         default: rd_val = '0;
      endcase
      rdata_d = bus.reg_rd ? rd_val : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q   <= '0;
         type_q  <= '0;
         out_q   <= '0;
         ie_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pend_q  <= '0;
         speed_q <= '0;
         pupd_q  <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
         sync_q  <= '0;
         prev_q  <= '0;
         warm_q  <= 2'd0;
         dly_q   <= 1'b0;
      end else begin
         dir_q   <= dir_d;
         type_q  <= type_d;
         out_q   <= out_d;
         ie_q    <= ie_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pend_q  <= pend_d;
         speed_q <= speed_d;
         pupd_q  <= pupd_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_in};
         prev_q  <= sync_in;
         dly_q   <= 1'b1;
         if (warm_inc && !edge_en) warm_q <= warm_q + 2'd1;
      end
   end

   assign pad_out       = out_q;
   assign pad_dir       = dir_q;
   assign pad_type      = type_q;
   assign pad_speed     = speed_q;
   assign pad_pupd      = pupd_q;
   assign irq           = irq_q;
   assign bus.reg_rdata = rdata_q;

endmodule
